// File: rtl/bcd_counter_ndigit.sv
// N-digit packed-BCD up/down counter with runtime modulus, synchronous load,
// and terminal-count / wrap outputs for cascading fields.
module bcd_counter_ndigit #(
  parameter int unsigned           DIGITS      = 4,
  parameter logic [4*DIGITS-1:0]   RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [4*DIGITS-1:0]   bcd_max,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  // True when every nibble is a legal BCD digit.
  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Ripple-carry BCD add of one; all-9s rolls to all-0s.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple-borrow BCD subtract of one; all-0s rolls to all-9s.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] eff_max;
  logic [W-1:0] max_m1;
  logic         full_range;
  logic         above_max;
  logic         load_ok;

  // Modulus decode. count_q and a valid eff_max are both legal BCD, so plain
  // binary magnitude compares order them correctly. Decrementing a zero
  // modulus yields all-9s, which is exactly the full-range top value.
  always_comb begin
    eff_max    = bcd_valid(bcd_max) ? bcd_max : '0;
    full_range = (eff_max == '0);
    max_m1     = bcd_dec(eff_max);
    above_max  = !full_range && (count_q >= eff_max);
    load_ok    = bcd_valid(load_value) && (full_range || (load_value < eff_max));
  end

  // Next-state: rst > load > en, otherwise hold.
  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) begin
        count_d = load_value;
      end else begin
        count_d    = '0;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if ((count_q == max_m1) || above_max) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = bcd_inc(count_q);
        end
      end else begin
        if (count_q == '0) begin
          count_d = max_m1;
          wrap_d  = 1'b1;
        end else if (above_max) begin
          // Modulus lowered below the count: clamp to the top, not a wrap.
          count_d = max_m1;
        end else begin
          count_d = bcd_dec(count_q);
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= RESET_VALUE;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  // Outputs; tc is combinational so a cascaded upper field steps on the same edge.
  always_comb begin
    count    = count_q;
    wrap     = wrap_q;
    load_err = load_err_q;
    tc       = en & (up ? (count_q == max_m1) : (count_q == '0));
  end

endmodule

// File: doc/bcd_counter_ndigit.md
# bcd_counter_ndigit

Registered N-digit packed-BCD up/down counter with a runtime modulus, synchronous load, and wrap/terminal-count outputs for cascading. It is the sequential, parametrised generalisation of the combinational 16-bit BCD incrementer. It serves as the counting element for the clock's seconds, minutes, hours and date fields and for the set-time editing path. One instance holds one field; fields cascade through `tc`.

## Interface
- `DIGITS`, default 4: number of BCD digits; counter width W = 4*DIGITS; legal range 1..8.
- `RESET_VALUE`, default 0: packed-BCD value loaded on reset; every digit must be ≤ 9 and the value must be below the reset-time modulus.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `en` in 1: count enable; one step per cycle while high.
- `up` in 1: direction; 1 = increment, 0 = decrement.
- `load` in 1: synchronous load of `load_value`.
- `load_value` in W: packed-BCD value to load.
- `bcd_max` in W: packed-BCD modulus; count range is 0 .. `bcd_max`−1; 0 means full range 0 .. 10^DIGITS−1.
- `count` out W: registered packed-BCD count.
- `tc` out 1: combinational terminal count: `en` & (`up` ? `count` == `bcd_max`−1 : `count` == 0); intended as `en` of the next-higher field.
- `wrap` out 1: registered one-cycle pulse, high in the cycle after a wrap edge.
- `load_err` out 1: registered one-cycle pulse, high in the cycle after a rejected load.

## Operation
- Priority per edge: `rst` > `load` > `en`; when none is active, `count` holds.
- Reset: `count`=`RESET_VALUE`, `wrap`=0, `load_err`=0.
- Load: accepted iff every digit of `load_value` is ≤ 9 and `load_value` < effective modulus.
  - Accepted: `count`←`load_value`.
  - Rejected: `count`←0 and `load_err` pulses.
  - `wrap` is 0 on any load cycle; `en` is ignored in a load cycle.
- Up step, per-digit BCD ripple-carry add of 1:
  - If `count` == `bcd_max`−1, or `count` ≥ `bcd_max` (modulus lowered at runtime): `count`←0 and `wrap` pulses.
  - With `bcd_max`=0: all-9s → all-0s with `wrap`.
  - Otherwise, any digit that reaches 10 becomes 0 and carries into the next digit.
- Down step, per-digit BCD ripple-borrow subtract of 1:
  - If `count` == 0: `count`←`bcd_max`−1 (all-9s when `bcd_max`=0) and `wrap` pulses.
  - If `count` ≥ `bcd_max` (and `bcd_max` ≠ 0): `count`←`bcd_max`−1, no `wrap`.
  - Otherwise, a digit at 0 borrows and becomes 9.
- `bcd_max`−1 is computed in BCD, not binary (e.g. 0x0060 → 0x0059).
- `bcd_max` containing a digit > 9 is treated as 0 (full range).
- `count` never holds an invalid BCD digit in any reachable state.
- No internal state besides `count`, `wrap`, `load_err`. The counter is direction-agnostic, so `up` may change every cycle.

## Timing
- Latency: one cycle from `en`/`load` sampled high to the updated `count`.
- `wrap` and `load_err` are asserted in the same cycle that `count` shows the wrapped or cleared value, and for exactly one cycle per event.
- `tc` is combinational from `count`, `en`, `up`, `bcd_max`, with no register stage. A cascade `lower.tc → upper.en` therefore steps both fields on the same edge.
- `rst` asserted mid-count or together with `load`/`en`: reset wins; the next cycle shows `RESET_VALUE` with `wrap`=`load_err`=0.
- Back-to-back enable gives one step per cycle; consecutive wraps produce consecutive `wrap` pulses.
- Critical path: DIGITS-long BCD ripple plus modulus compare; 8 digits must meet the project clock.

## Test plan
- `DIGITS`=4, `bcd_max`=0x0060, `up`=1, `en`=1 from 0x0057 → `count` 0x0058, 0x0059, 0x0000. `wrap` is high only in the 0x0000 cycle; `tc` is high only while `count`=0x0059.
- `bcd_max`=0x0000, `count`=0x0999, up step → 0x1000, no `wrap`. From 0x9999, up step → 0x0000 with `wrap`.
- `bcd_max`=0x0024, `up`=0, from 0x0001 → 0x0000, then 0x0023 with `wrap`. From 0x0010, down step → 0x0009.
- `load`=1, `load_value`=0x00A5 → `count`=0x0000, `load_err` pulse. `load_value`=0x0030 with `bcd_max`=0x0024 → 0x0000, `load_err`. `load_value`=0x0017 → 0x0017, no pulse.
- `count`=0x0045, `bcd_max` changed to 0x0024. Up step → 0x0000 with `wrap`; alternatively a down step → 0x0023 without `wrap`.
- `rst`, `load` and `en` all high together at `count`=0x0033 → next cycle `count`=`RESET_VALUE`, `wrap`=0, `load_err`=0. Two cascaded instances (60/24) via `tc` roll 23:59 → 00:00 on a single edge.
